fetch_stage: RTL

- Instruction-fetch stage that feeds the byte-addressed, little-endian instruction memory.
- Holds the program counter and drives the memory address with read-only control.
- Captures the combinationally returned word into an IF/ID register for decode.
- Handles decode stalls, branch/jump redirects with a one-slot bubble, misaligned targets, out-of-range fetches and a retired-fetch counter.

---
 rtl/fetch_stage.sv | 71 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads instruction memory and fills the IF/ID
// register, with stall hold, redirect bubble, range check and fetch counting.
`ifndef MEM_DEPTH
`define MEM_DEPTH 1024
`endif

module fetch_stage #(
    parameter logic [31:0] START_ADDR = 32'h0100_0000,
    parameter int unsigned MEM_DEPTH  = `MEM_DEPTH,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_address,
    output logic        imem_read_write,
    output logic [31:0] imem_data_in,
    output logic [31:0] pc,
    output logic [31:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_valid,
    output logic        misaligned_fault,
    output logic [31:0] fetch_count
);

    logic [31:0] offset;
    logic [32:0] last_byte;
    logic        in_range;

    // 33-bit compare so a PC below START_ADDR can never wrap back into range
    assign offset    = pc - START_ADDR;
    assign last_byte = {1'b0, offset} + 33'd3;
    assign in_range  = last_byte < 33'(MEM_DEPTH);

    assign imem_address    = pc;
    assign imem_read_write = 1'b0;
    assign imem_data_in    = 32'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc               <= START_ADDR;
            if_pc            <= 32'h0;
            if_insn          <= NOP_INSN;
            if_valid         <= 1'b0;
            misaligned_fault <= 1'b0;
            fetch_count      <= 32'h0;
        end else if (redirect) begin
            pc       <= {redirect_target[31:2], 2'b00};
            if_pc    <= pc;
            if_insn  <= NOP_INSN;
            if_valid <= 1'b0;
            if (redirect_target[1:0] != 2'b00)
                misaligned_fault <= 1'b1;
        end else if (!stall) begin
            pc    <= pc + 32'd4;
            if_pc <= pc;
            if (in_range) begin
                if_insn     <= imem_data;
                if_valid    <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end else begin
                if_insn  <= NOP_INSN;
                if_valid <= 1'b0;
            end
        end
    end

endmodule
